matrix_load_ctrl: RTL and testbench
===================================

// Module: matrix_load_ctrl
// PURPOSE
//  Sequencer directly upstream of the matrix multiply unit.
//  - Accepts a byte stream (valid/ready) and fills the A then B operand buffers, row-major.
//  - Pulses start, waits for done (or a timeout), then streams the C result out (valid/ready).
//  - Sits between the accelerator's bus-side FIFO and the multiply core; owns the 1024x8 operand storage.
// PARAMETERS
//  MAT_SIZE     2     matrix dimension; N = MAT_SIZE*MAT_SIZE elements per matrix (N <= 1024)
//  DAT_SIZE     8     element width in bits (fixed 8 in this revision)
//  DONE_TIMEOUT 4     cycles in WAIT_DONE before forcing completion; sets timeout_err
// PORTS
//  clk          in   1         clock
//  rst          in   1         asynchronous reset, active-high
//  in_valid     in   1         input element valid
//  in_data      in   8         input element (A elements first, then B)
//  in_ready     out  1         loader accepts in_data this cycle
//  mat_A        out  1024x8    operand A buffer, element i at [i]
//  mat_B        out  1024x8    operand B buffer
//  start        out  1         one-cycle pulse to multiplier
//  done         in   1         multiplier completion (level or pulse; first high cycle counts)
//  mat_C        in   1024x8    multiplier result
//  out_valid    out  1         result element valid
//  out_data     out  8         result element, row-major from index 0
//  out_ready    in   1         downstream accepts out_data
//  busy         out  1         high in any state except LOAD_A with idx==0
//  timeout_err  out  1         sticky; set on timeout, cleared only by rst
// BEHAVIOUR
//  Reset (async, any state): state=LOAD_A, idx=0, mat_A/mat_B all 0, start=0,
//   out_valid=0, out_data=0, timeout_err=0, tmr=0; in_ready=1 one cycle after rst drops.
//  idx: counter of width clog2(N)+1, shared by all phases; resets to 0 on every state change.
//  LOAD_A: in_ready=1; on in_valid&&in_ready: mat_A[idx]<=in_data, idx++.
//   Accepting element idx==N-1 -> LOAD_B.
//  LOAD_B: same, writing mat_B; element N-1 accepted -> KICK.
//   in_ready=0 in every other state.
//  KICK: start=1 for exactly one cycle -> WAIT_DONE; tmr=0.
//  WAIT_DONE: tmr++ each cycle.
//   done=1 -> DRAIN (done is ignored in every other state).
//   tmr==DONE_TIMEOUT-1 with done=0 -> DRAIN, timeout_err<=1.
//   done high in the same cycle as the timeout -> no error.
//  DRAIN: out_valid=1, out_data=mat_C[idx] (registered, sampled on entry / after each transfer).
//   On out_valid&&out_ready: idx++.
//   Last element (idx==N-1) transferred -> LOAD_A, out_valid=0 next cycle.
//   out_ready held low: out_valid and out_data stable (no drop, no change).
//  A/B buffers are not cleared between jobs; entries >= N are never written.
//  Latency: last B byte accepted at cycle t -> start at t+1 -> first out_valid at
//   (done cycle)+1.
//  No bypass: in_valid during KICK/WAIT_DONE/DRAIN is back-pressured, never dropped.
// STRUCTURE
//  Package matrix_acc_pkg:
//   - typedef logic [7:0] elem_t
//   - typedef elem_t [1023:0] mat_t
//   - localparam MAX_ELEMS=1024
//   - enum state_t {LOAD_A, LOAD_B, KICK, WAIT_DONE, DRAIN}
//  Single module; no sub-module (counter and FSM are small). Elaboration-time assert N<=MAX_ELEMS.
// TESTING
//  1 Reset: hold rst mid-DRAIN -> state LOAD_A, out_valid=0, start=0, timeout_err=0,
//    mat_A[0]=0 immediately.
//  2 Load MAT_SIZE=2, stream 1,2,3,4,5,6,7,8 with in_valid always 1
//    -> mat_A[3:0]={4,3,2,1}, mat_B[3:0]={8,7,6,5}, single start pulse 1 cycle after byte 8.
//  3 done asserted 1 cycle after start, mat_C[3:0]={4,3,2,1}, out_ready=1
//    -> out_data 1,2,3,4 on 4 consecutive cycles, then in_ready=1.
//  4 Back-pressure: out_ready toggled 0/1 each cycle in DRAIN
//    -> each element held while out_ready=0, exactly 4 transfers, no duplicates.
//  5 Timeout: done held 0 -> DRAIN entered after 4 WAIT_DONE cycles, timeout_err=1,
//    stays 1 through the next job.
//  6 in_valid gaps (1-of-3 duty) during load, plus in_valid=1 during WAIT_DONE
//    -> in_ready=0 there, no extra writes, correct buffers.

Source files
------------

// File: rtl/matrix_acc_pkg.sv
// matrix_acc_pkg: shared types and limits for the matrix accelerator datapath.
package matrix_acc_pkg;
  localparam int MAX_ELEMS = 1024;
  typedef logic [7:0] elem_t;
  typedef elem_t [MAX_ELEMS-1:0] mat_t;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, KICK, WAIT_DONE, DRAIN} state_t;
endpackage

// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl: fills A/B operand buffers from a byte stream, kicks the multiplier, drains C.
module matrix_load_ctrl
  import matrix_acc_pkg::*;
#(
  parameter int MAT_SIZE     = 2,
  parameter int DAT_SIZE     = 8,
  parameter int DONE_TIMEOUT = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  elem_t in_data,
  output logic  in_ready,
  output mat_t  mat_A,
  output mat_t  mat_B,
  output logic  start,
  input  logic  done,
  input  mat_t  mat_C,
  output logic  out_valid,
  output elem_t out_data,
  input  logic  out_ready,
  output logic  busy,
  output logic  timeout_err
);
  localparam int N  = MAT_SIZE * MAT_SIZE;
  localparam int IW = $clog2(N) + 1;
  localparam int TW = $clog2(DONE_TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(DONE_TIMEOUT - 1);

  if (N > MAX_ELEMS || DAT_SIZE != 8) begin : g_bad_cfg
    $error("matrix_load_ctrl: unsupported MAT_SIZE/DAT_SIZE");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  mat_t          mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  elem_t         out_data_q, out_data_d;
  logic          err_q, err_d;
  logic          in_acc, last;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    in_acc      = in_valid && in_ready_q;
    last        = idx_q == LAST;
    case (state_q)
      LOAD_A, LOAD_B: if (in_acc) begin
        if (state_q == LOAD_A) mat_a_d[idx_q] = in_data;
        else mat_b_d[idx_q] = in_data;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = !last ? state_q : (state_q == LOAD_A ? LOAD_B : KICK);
      end
      KICK: begin
        state_d = WAIT_DONE;
        tmr_d   = '0;
      end
      WAIT_DONE: begin
        tmr_d = tmr_q + 1'b1;
        if (done || tmr_q == TLAST) begin
          state_d     = DRAIN;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = mat_C[0];
          err_d       = err_q | !done;
        end
      end
      DRAIN: if (out_ready) begin
        state_d     = last ? LOAD_A : DRAIN;
        idx_d       = last ? '0 : idx_q + 1'b1;
        out_valid_d = !last;
        out_data_d  = last ? out_data_q : mat_C[idx_q + 1'b1];
      end
      default: state_d = LOAD_A;
    endcase
    // Registered so it stays low while rst is held and rises one edge later.
    in_ready_d = state_d == LOAD_A || state_d == LOAD_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      tmr_q       <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mat_A       = mat_a_q;
  assign mat_B       = mat_b_q;
  assign start       = state_q == KICK;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = !(state_q == LOAD_A && idx_q == '0);
  assign timeout_err = err_q;
endmodule

// File: tb/tb_matrix_load_ctrl.sv
// tb_matrix_load_ctrl: randomized jobs checked against a phase-level model of load/kick/wait/drain.
module tb_matrix_load_ctrl;
  import matrix_acc_pkg::*;
  localparam int N = 4;
  localparam int TMO = 4;

  logic  clk = 0, rst = 1;
  logic  in_valid = 0, done = 0, out_ready = 0;
  elem_t in_data = '0;
  mat_t  mat_C = '0;
  logic  in_ready, start, out_valid, busy, timeout_err;
  elem_t out_data;
  mat_t  mat_A, mat_B;
  int    checks = 0, errors = 0;
  logic  exp_err = 0;

  matrix_load_ctrl #(.MAT_SIZE(2), .DAT_SIZE(8), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_A(mat_A), .mat_B(mat_B), .start(start), .done(done), .mat_C(mat_C),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One job: vpct = in_valid duty %, rpct = out_ready duty % (-1 toggles), dd = WAIT_DONE cycles before done.
  task automatic run_job(input bit seq, input int vpct, input int rpct, input int dd, input bit abort);
    elem_t a[N], b[N], c[N];
    int sent = 0, k = 0, budget = 0;
    bit timed_out;
    for (int i = 0; i < N; i++) begin
      a[i] = seq ? elem_t'(i + 1) : elem_t'($urandom);
      b[i] = seq ? elem_t'(i + 5) : elem_t'($urandom);
      c[i] = seq ? elem_t'(i + 1) : elem_t'($urandom);
      mat_C[i] = c[i];
    end
    while (sent < 2 * N && budget < 500) begin
      @(negedge clk);
      budget++;
      chk("load_in_ready", in_ready, 1);
      chk("load_start", start, 0);
      in_valid = ($urandom_range(99) < vpct);
      in_data = in_valid ? (sent < N ? a[sent] : b[sent - N]) : 8'hA5;
      @(posedge clk);
      if (in_valid) sent++;
    end
    if (sent < 2 * N) chk("load_budget", sent, 2 * N);
    @(negedge clk);
    in_valid = 1;
    in_data = 8'hEE;
    chk("kick_start", start, 1);
    chk("kick_in_ready", in_ready, 0);
    chk("kick_busy", busy, 1);
    for (int i = 0; i < N; i++) begin
      chk("mat_A", mat_A[i], a[i]);
      chk("mat_B", mat_B[i], b[i]);
    end
    chk("mat_A_unused", mat_A[N], 0);
    chk("mat_B_unused", mat_B[N], 0);
    timed_out = 0;
    for (int w = 0; w < TMO; w++) begin
      @(negedge clk);
      chk("wait_start", start, 0);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_out_valid", out_valid, 0);
      done = (w >= dd);
      if (done) break;
      timed_out = (w == TMO - 1);
    end
    exp_err = exp_err | timed_out;
    budget = 0;
    out_ready = 0;
    while (k < N && budget < 500) begin
      @(negedge clk);
      budget++;
      in_valid = 0;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, c[k]);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_err", timeout_err, exp_err);
      if (abort && k == 2) begin
        #2 rst = 1;
        #1;
        exp_err = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start", start, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_matA0", mat_A[0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        done = 0;
        out_ready = 0;
        @(negedge clk);
        rst = 0;
        #1 chk("rst_drop_in_ready", in_ready, 0);
        @(posedge clk);
        #1 chk("rst_after_in_ready", in_ready, 1);
        return;
      end
      out_ready = rpct < 0 ? ~out_ready : ($urandom_range(99) < rpct);
      @(posedge clk);
      if (out_ready) k++;
    end
    if (k < N) chk("drain_budget", k, N);
    @(negedge clk);
    done = 0;
    out_ready = 0;
    chk("end_out_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_err", timeout_err, exp_err);
    chk("end_matA0", mat_A[0], a[0]);
    chk("end_matB_last", mat_B[N - 1], b[N - 1]);
  endtask

  initial begin
    #3;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_start", start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1 chk("post_reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1 chk("post_reset_in_ready1", in_ready, 1);
    run_job(1, 100, 100, 0, 0);
    run_job(0, 100, 100, 3, 0);
    run_job(0, 70, -1, 1, 0);
    run_job(0, 80, 50, 6, 0);
    run_job(0, 33, 60, 1, 0);
    for (int j = 0; j < 8; j++)
      run_job(0, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 5), 0);
    run_job(0, 90, 100, 5, 1);
    run_job(0, 50, 50, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
